// File: rtl/intdiv_mulrecon.sv
// Rebuilds the dividend x = z*y + r from a divider result with a radix-2 Booth multiply and checks the remainder contract.
// Latency: out_valid rises N+1 cycles after the accept edge; back-to-back initiation every N+3 cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module intdiv_mulrecon #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   z,
  input  logic signed [N-1:0]   y,
  input  logic signed [N-1:0]   r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N-1:0] x_full,
  output logic [N-1:0]          x,
  output logic                  ovf,
  output logic                  rem_ok
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADD, S_DONE} state_t;

  localparam logic [N:0] ONE_N1 = {{N{1'b0}}, 1'b1};

  state_t                r_state;
  logic signed [N:0]     r_a;        // Booth accumulator, one bit wider than operands
  logic signed [N:0]     r_m;        // sign-extended multiplicand (y)
  logic [N-1:0]          r_q;        // multiplier (z), shifted out as product low half
  logic                  r_qp;       // Booth look-behind bit
  logic [CW-1:0]         r_cnt;
  logic signed [N-1:0]   r_rem;
  logic signed [2*N-1:0] r_x_full;
  logic                  r_ovf;
  logic                  r_rem_ok;
  logic                  r_out_valid;

  logic signed [N:0]     w_a_sum;
  logic [1:0]            w_pair;
  logic [2*N-1:0]        w_prod;
  logic [2*N-1:0]        w_r_ext;
  logic [2*N-1:0]        w_xsum;
  logic [N:0]            w_r_sx;
  logic [N:0]            w_r_mag;
  logic [N:0]            w_y_mag;
  logic                  w_ovf;
  logic                  w_rem_ok;

  assign w_pair  = {r_q[0], r_qp};
  assign w_prod  = {r_a[N-1:0], r_q};
  assign w_r_ext = {{N{r_rem[N-1]}}, r_rem};
  assign w_xsum  = w_prod + w_r_ext;
  assign w_r_sx  = {r_rem[N-1], r_rem};
  // Magnitudes are N+1 bits so that |-2^(N-1)| is representable.
  assign w_r_mag = r_rem[N-1] ? (~w_r_sx + ONE_N1) : w_r_sx;
  assign w_y_mag = r_m[N]     ? (~r_m + ONE_N1)    : r_m;
  assign w_ovf   = !((&w_xsum[2*N-1:N-1]) || !(|w_xsum[2*N-1:N-1]));
  assign w_rem_ok = (r_m != '0) && (w_r_mag < w_y_mag) &&
                    ((r_rem == '0) || (r_rem[N-1] == w_xsum[2*N-1]));

  // Booth add/subtract selected by the current multiplier pair.
  always_comb begin
    w_a_sum = r_a;
    if (w_pair == 2'b10)      w_a_sum = r_a - r_m;
    else if (w_pair == 2'b01) w_a_sum = r_a + r_m;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign x_full    = r_x_full;
  assign x         = r_x_full[N-1:0];
  assign ovf       = r_ovf;
  assign rem_ok    = r_rem_ok;

  // Control FSM with datapath: accept, N Booth steps, final add of r, hold result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_qp        <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_x_full    <= '0;
      r_ovf       <= 1'b0;
      r_rem_ok    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= '0;
            r_m     <= {y[N-1], y};
            r_q     <= z;
            r_qp    <= 1'b0;
            r_rem   <= r;
            r_cnt   <= CW'(N-1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Arithmetic right shift of {A, Q, q_prev} after the add.
          r_a  <= {w_a_sum[N], w_a_sum[N:1]};
          r_q  <= {w_a_sum[0], r_q[N-1:1]};
          r_qp <= r_q[0];
          if (r_cnt == '0) r_state <= S_ADD;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_ADD: begin
          r_x_full    <= w_xsum;
          r_ovf       <= w_ovf;
          r_rem_ok    <= w_rem_ok;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_mulrecon.sv
// Self-checking bench for intdiv_mulrecon: directed table, random ops against an arithmetic model, corner sequences.
// Latency: checks out_valid N+1 cycles after accept and an initiation interval of N+3.
// Backpressure: holds out_ready low in DONE and checks outputs stay stable.
module tb_intdiv_mulrecon;
  localparam int N = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [N-1:0]   z, y, r;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*N-1:0] x_full;
  logic [N-1:0]          x;
  logic                  ovf, rem_ok;

  int n_chk  = 0;
  int n_fail = 0;

  longint g_xf;
  longint g_x;
  longint g_ovf;
  longint g_rok;

  typedef struct {
    int zz, yy, rr;
    int xf;
    int ov, rok;
  } vec_t;

  vec_t tbl[10];

  intdiv_mulrecon #(.N(N), .CW(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .y(y), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .x_full(x_full), .x(x), .ovf(ovf), .rem_ok(rem_ok)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // x = z*y + r using plain integers; contract judged from the mathematical values.
  task automatic ref_model(input int zz, input int yy, input int rr,
                           output int xf, output int ov, output int rok);
    int ar, ay;
    xf  = zz * yy + rr;
    ov  = (xf < -(1 << (N-1)) || xf > (1 << (N-1)) - 1) ? 1 : 0;
    ar  = (rr < 0) ? -rr : rr;
    ay  = (yy < 0) ? -yy : yy;
    rok = ((yy != 0) && (ar < ay) && ((rr == 0) || ((rr < 0) == (xf < 0)))) ? 1 : 0;
  endtask

  // One full operation; captures the result into g_* and checks latency and handshake.
  task automatic do_op(input int zz, input int yy, input int rr, input int hold);
    int lat;
    @(negedge clock);
    chk("in_ready_idle", longint'(in_ready), 1);
    in_valid  = 1'b1;
    z = N'(zz); y = N'(yy); r = N'(rr);
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    z = N'($urandom); y = N'($urandom); r = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
      if (hold == 0) out_ready = 1'($urandom);
      z = N'($urandom);
    end
    chk("latency", lat, N + 1);
    g_xf  = longint'(x_full);
    g_x   = longint'(x);
    g_ovf = longint'(ovf);
    g_rok = longint'(rem_ok);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_x", longint'(x), g_x);
      chk("hold_flags", longint'({ovf, rem_ok}), (g_ovf << 1) | g_rok);
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("release_valid", longint'(out_valid), 0);
    chk("release_in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int xf, ov, rok, cnt, bad;
    tbl[0] = '{4, 7, 2, 30, 0, 1};
    tbl[1] = '{-10, 11, -10, -120, 0, 1};
    tbl[2] = '{-128, -128, 0, 16384, 1, 1};
    tbl[3] = '{4, 7, -2, 26, 0, 0};
    tbl[4] = '{5, 0, 3, 3, 0, 0};
    tbl[5] = '{3, 3, 1, 10, 0, 1};
    tbl[6] = '{-128, 127, -127, -16383, 1, 0};
    tbl[7] = '{127, -128, -128, -16384, 1, 0};
    tbl[8] = '{0, -5, -4, -4, 0, 1};
    tbl[9] = '{-1, 1, 0, -1, 0, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    z = '0; y = '0; r = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_x_full", longint'(x_full), 0);
    chk("rst_x", longint'(x), 0);
    chk("rst_flags", longint'({ovf, rem_ok}), 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].zz, tbl[i].yy, tbl[i].rr, 0);
      chk($sformatf("tbl%0d_x_full", i), g_xf, longint'(tbl[i].xf));
      chk($sformatf("tbl%0d_x", i), g_x, longint'(tbl[i].xf) & 64'hFF);
      chk($sformatf("tbl%0d_ovf", i), g_ovf, longint'(tbl[i].ov));
      chk($sformatf("tbl%0d_rem_ok", i), g_rok, longint'(tbl[i].rok));
    end

    // Random operands against the model; r is biased small so rem_ok is often true.
    for (int i = 0; i < 40; i++) begin
      int zz, yy, rr;
      zz = int'($urandom_range(255)) - 128;
      yy = int'($urandom_range(255)) - 128;
      if (i % 2 == 0) rr = int'($urandom_range(255)) - 128;
      else            rr = int'($urandom_range(20)) - 10;
      ref_model(zz, yy, rr, xf, ov, rok);
      do_op(zz, yy, rr, 0);
      chk("rnd_x_full", g_xf, longint'(xf));
      chk("rnd_x", g_x, longint'(xf) & 64'hFF);
      chk("rnd_ovf", g_ovf, longint'(ov));
      chk("rnd_rem_ok", g_rok, longint'(rok));
    end

    // Backpressure: result held five cycles.
    do_op(4, 7, 2, 5);
    chk("bp_x", g_x, 30);
    chk("bp_rem_ok", g_rok, 1);

    // Reset three cycles into RUN aborts the operation.
    @(negedge clock);
    in_valid = 1'b1; z = 8'sd100; y = 8'sd100; r = 8'sd5;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_x_full", longint'(x_full), 0);
    chk("abort_flags", longint'({ovf, rem_ok}), 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (out_valid) bad++;
    end
    chk("abort_no_spurious", bad, 0);
    do_op(3, 3, 1, 0);
    chk("after_abort_x", g_x, 10);

    // in_valid held high with out_ready high: next accept N+3 cycles later.
    @(negedge clock);
    in_valid = 1'b1; out_ready = 1'b1; z = 8'sd2; y = 8'sd3; r = 8'sd1;
    @(posedge clock);
    @(negedge clock);
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    chk("b2b_interval", cnt + 1, N + 3);
    @(negedge clock);
    chk("b2b_reaccept", longint'(in_ready), 0);
    in_valid = 1'b0;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    chk("b2b_second_done", longint'(in_ready), 1);
    chk("b2b_second_x", longint'(x), 7);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intdiv_mulrecon.md
Name: intdiv_mulrecon

Overview:
- Sequential signed multiply-accumulate that rebuilds the dividend from a divider result: x = z*y + r.
- Inputs are quotient z, divisor y and remainder r. It checks that r meets the divider's truncating-remainder contract.
- Sits downstream of the pipelined divider as a result checker and reconstruction unit. Uses radix-2 Booth, one iteration per clock, with valid/ready handshakes on both sides.

Parameters:
- N, 8, operand width in bits (two's complement); N >= 4.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  z/y/r valid.
- in_ready  output  1  block can accept operands.
- z  input  N  signed quotient.
- y  input  N  signed divisor.
- r  input  N  signed remainder.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- x_full  output  2N  signed exact z*y+r.
- x  output  N  low N bits of x_full.
- ovf  output  1  x_full not representable in N signed bits.
- rem_ok  output  1  remainder contract satisfied.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high, on ports clock and reset.
- Reset values: state=IDLE, out_valid=0, x_full=0, x=0, ovf=0, rem_ok=0, counter=0. in_ready=1 in the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1. On in_valid, latch z, y, r, clear accumulator A, set q_prev=0, counter=N-1, go to RUN.
  - RUN: one Booth step per cycle on {A[N:0], Q[N-1:0], q_prev}, with Q initialised to z and multiplicand sext(y) to N+1 bits.
    - Pair 10: A -= y. Pair 01: A += y. Pair 00 or 11: no add.
    - Then arithmetic right shift of the whole register by 1.
    - Counter decrements each step; the step taken with counter=0 moves to ADD.
  - ADD: x_full <= {A[N-1:0], Q} + sext(r) to 2N bits. Register ovf and rem_ok. Set out_valid=1, go to DONE.
  - DONE: outputs held stable. When out_ready=1, clear out_valid and go to IDLE.
- in_ready is 1 only in IDLE. in_ready is a pure decode of state.
- Latency: accept on edge t0; out_valid=1 after edge t0+N+1. Back-to-back initiation interval is N+3 cycles with out_ready tied high.
- Arithmetic: the product magnitude is at most 2^(2N-2). |r| is at most 2^(N-1). x_full is therefore exact in 2N bits with no wrap.
- ovf = 1 iff x_full[2N-1:N-1] is not all-equal.
- rem_ok = 1 iff all of the following hold:
  - y != 0;
  - |r| < |y|, compared as N+1-bit magnitudes so the most negative values are handled;
  - r == 0 or sign(r) == sign(x_full).
- y=0: multiply proceeds normally (x_full = r) and rem_ok=0.
- z = -2^(N-1) and y = -2^(N-1): the Booth A register is N+1 bits wide, so there is no intermediate overflow.
- Operands are sampled only at the IDLE accept edge. Later input changes have no effect.
- out_ready asserted outside DONE is ignored.
- Reset mid-operation (RUN/ADD/DONE): abort, discard the operation, return to IDLE with reset values. No spurious out_valid.
- in_valid held high across a completed operation starts a new accept only after returning to IDLE.

Test Plan:
- N=8. z=4, y=7, r=2, out_ready=1 -> out_valid exactly 9 cycles after the accept edge, x=30, x_full=30, ovf=0, rem_ok=1.
- z=-10, y=11, r=-10 -> x=-120 (0x88), ovf=0, rem_ok=1.
- z=-128, y=-128, r=0 -> x_full=16384 (0x4000), x=0x00, ovf=1, rem_ok=1.
- z=4, y=7, r=-2 -> x=26, rem_ok=0 (sign mismatch). Then z=5, y=0, r=3 -> x=3, rem_ok=0.
- Backpressure: result ready, out_ready low for 5 cycles -> out_valid, x, ovf and rem_ok stable and in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Reset asserted 3 cycles into RUN -> next cycle out_valid=0, in_ready=1, outputs zero. A following operation z=3, y=3, r=1 gives x=10.
